retry_inorder_ctrl: RTL

Retry scheduler for the in-order retry start stage. It tracks the window of issued-but-unretired IDs and accepts failure reports from the downstream checker. On a failure it locks new input and replays, in order, every ID from the failed one to the newest issued. It bounds consecutive retries and reports window-full and fatal error.

---
 rtl/retry_ctrl_pkg.sv | 37 +++
 rtl/retry_inorder_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/retry_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : retry_ctrl_pkg
// Purpose  : Shared types and helpers for the in-order retry scheduler.
//            Holds the FSM state enum and the modular window-membership
//            arithmetic used on wrapping IDs.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package retry_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1,
    ERROR  = 2'd2
  } retry_ctrl_state_e;

  // Widest ID the helpers accept; callers zero-extend narrower IDs and pass
  // a mask so the subtraction wraps at the caller's own ID width.
  localparam int unsigned MaxIdSize = 16;
  typedef logic [MaxIdSize-1:0] id_t;

  // x is in the window iff its wrapped distance from the oldest ID is
  // smaller than the number of outstanding IDs.
  function automatic logic id_in_window(input id_t x, input id_t oldest,
                                        input id_t count, input id_t id_mask);
    id_t offset;
    offset = (x - oldest) & id_mask;
    return offset < count;
  endfunction

  function automatic logic window_full(input id_t count, input id_t window_depth);
    return count == window_depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/retry_inorder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : retry_inorder_ctrl
// Purpose  : Retry scheduler for the in-order retry start stage. Tracks the
//            window of issued-but-unretired IDs, accepts failure reports,
//            replays every ID from the failed one to the newest issued, bounds
//            consecutive retry episodes and flags a sticky fatal error.
// Ports    : clk_i, rst_ni        clock, async active-low reset
//            issue_id_i/valid_i   IDs accepted by the start stage
//            done_id_i/valid_i    IDs checked OK downstream
//            fail_id_i/valid_i,
//            fail_ready_o         failure report handshake
//            retry_id_o/valid_o,
//            retry_ready_i        replay stream to the start stage
//            retry_lock_o         blocks new input while replaying / in error
//            full_o               window full
//            error_o, clear_i     sticky fatal error and its release
// Revision : 1.0 - initial release
// ============================================================================
module retry_inorder_ctrl
  import retry_ctrl_pkg::*;
#(
  parameter int unsigned IDSize     = 3,
  parameter int unsigned MaxRetries = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDSize-1:0] issue_id_i,
  input  logic              issue_valid_i,
  input  logic [IDSize-1:0] done_id_i,
  input  logic              done_valid_i,
  input  logic [IDSize-1:0] fail_id_i,
  input  logic              fail_valid_i,
  output logic              fail_ready_o,
  output logic [IDSize-1:0] retry_id_o,
  output logic              retry_valid_o,
  input  logic              retry_ready_i,
  output logic              retry_lock_o,
  output logic              full_o,
  output logic              error_o,
  input  logic              clear_i
);

  localparam id_t               IdMask      = id_t'((32'd1 << IDSize) - 32'd1);
  localparam id_t               WindowDepth = id_t'(32'd1 << (IDSize - 1));
  localparam int unsigned       RcntW       = $clog2(MaxRetries + 1);
  localparam logic [IDSize-1:0] IdOne       = IDSize'(1);
  localparam logic [RcntW-1:0]  RcntOne     = RcntW'(1);
  localparam logic [RcntW-1:0]  RcntMax     = RcntW'(MaxRetries);

  retry_ctrl_state_e state_q, state_d;
  logic [IDSize-1:0] oldest_q, oldest_d;
  logic [IDSize-1:0] next_q, next_d;
  logic [IDSize-1:0] ptr_q, ptr_d;
  logic [IDSize-1:0] end_q, end_d;
  logic [RcntW-1:0]  rcnt_q, rcnt_d;

  logic [IDSize-1:0] count;
  logic              fail_in_win;
  logic              fail_acc;
  logic              done_ok;
  logic [RcntW-1:0]  rcnt_base;

  assign count         = next_q - oldest_q;
  assign full_o        = window_full(id_t'(count), WindowDepth);
  assign fail_ready_o  = (state_q != REPLAY);
  assign retry_valid_o = (state_q == REPLAY);
  assign retry_id_o    = retry_valid_o ? ptr_q : '0;
  // Decoded from the state register, so it changes only the cycle after
  // the state does.
  assign retry_lock_o  = (state_q != IDLE);
  assign error_o       = (state_q == ERROR);

  always_comb begin
    state_d   = state_q;
    oldest_d  = oldest_q;
    ptr_d     = ptr_q;
    end_d     = end_q;
    rcnt_d    = rcnt_q;
    rcnt_base = rcnt_q;

    next_d      = issue_valid_i ? (next_q + IdOne) : next_q;
    fail_acc    = fail_valid_i && fail_ready_o;
    fail_in_win = id_in_window(id_t'(fail_id_i), id_t'(oldest_q), id_t'(count), IdMask);

    // A done for the same ID as an accepted failure loses to the failure.
    done_ok = done_valid_i && (done_id_i == oldest_q) && (count != '0) &&
              !(fail_acc && (fail_id_i == done_id_i));

    if (done_ok) begin
      oldest_d  = oldest_q + IdOne;
      rcnt_d    = '0;
      rcnt_base = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (fail_valid_i && fail_in_win) begin
          if (rcnt_base == RcntMax) begin
            state_d = ERROR;
          end else begin
            ptr_d    = fail_id_i;
            end_d    = next_d - IdOne;
            // Replayed elements come back with fresh IDs starting at next_d.
            oldest_d = next_d;
            rcnt_d   = rcnt_base + RcntOne;
            state_d  = REPLAY;
          end
        end
      end
      REPLAY: begin
        if (retry_ready_i) begin
          if (ptr_q == end_q) state_d = IDLE;
          else                ptr_d   = ptr_q + IdOne;
        end
      end
      ERROR: begin
        if (clear_i) begin
          state_d  = IDLE;
          oldest_d = next_q;
          rcnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // An out-of-order issue means the tracking is corrupt; it overrides all.
    if (issue_valid_i && (issue_id_i != next_q)) state_d = ERROR;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      oldest_q <= '0;
      next_q   <= '0;
      ptr_q    <= '0;
      end_q    <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      oldest_q <= oldest_d;
      next_q   <= next_d;
      ptr_q    <= ptr_d;
      end_q    <= end_d;
      rcnt_q   <= rcnt_d;
    end
  end

endmodule
`default_nettype wire
